// File: rtl/cam_lookup_ctrl.sv
// rtl/cam_lookup_ctrl.sv - CAM write/lookup sequencer, one operation outstanding.
// Writes win over lookups in IDLE; lookup results are held until consumed.
module cam_lookup_ctrl #(
   parameter int C_TCAM_ADDR_WIDTH = 5,
   parameter int C_TCAM_DATA_WIDTH = 16,
   parameter int C_LOOKUP_LATENCY  = 1
) (
   input  logic                         CLK,
   input  logic                         RST,
   input  logic                         wr_req_valid,
   output logic                         wr_req_ready,
   input  logic [C_TCAM_ADDR_WIDTH-1:0] wr_req_addr,
   input  logic [C_TCAM_DATA_WIDTH-1:0] wr_req_data,
   input  logic                         lk_req_valid,
   output logic                         lk_req_ready,
   input  logic [C_TCAM_DATA_WIDTH-1:0] lk_req_key,
   output logic                         lk_rsp_valid,
   input  logic                         lk_rsp_ready,
   output logic                         lk_rsp_hit,
   output logic [C_TCAM_ADDR_WIDTH-1:0] lk_rsp_addr,
   output logic                         cam_we,
   output logic [C_TCAM_ADDR_WIDTH-1:0] cam_addr_wr,
   output logic [C_TCAM_DATA_WIDTH-1:0] cam_din,
   input  logic                         cam_busy,
   output logic [C_TCAM_DATA_WIDTH-1:0] cam_cmp_din,
   input  logic                         cam_match,
   input  logic [C_TCAM_ADDR_WIDTH-1:0] cam_match_addr,
   output logic [31:0]                  stat_lookups,
   output logic [31:0]                  stat_hits
);

   localparam logic [2:0] LAT = 3'(C_LOOKUP_LATENCY);

   typedef enum logic [2:0] {IDLE, WR_ISSUE, WR_WAIT, LK_WAIT, LK_RESP} state_t;
   state_t state, state_nxt;

   logic [C_TCAM_ADDR_WIDTH-1:0] wr_addr_q;
   logic [C_TCAM_DATA_WIDTH-1:0] wr_data_q;
   logic [C_TCAM_DATA_WIDTH-1:0] key_q;
   logic [2:0]                   lat_cnt;
   logic                         settle;
   logic                         wr_acc;
   logic                         lk_acc;
   logic                         sample;

   assign wr_acc = wr_req_valid & wr_req_ready;
   assign lk_acc = lk_req_valid & lk_req_ready;
   assign sample = (state == LK_WAIT) && (lat_cnt == 3'd0);

   always_comb begin
      state_nxt    = state;
      wr_req_ready = 1'b0;
      lk_req_ready = 1'b0;
      cam_we       = 1'b0;
      cam_addr_wr  = '0;
      cam_din      = '0;
      cam_cmp_din  = '0;
      lk_rsp_valid = 1'b0;
      case (state)
         IDLE: begin
            // Readies are also gated by RST so nothing looks acceptable during reset.
            wr_req_ready = ~cam_busy & ~RST;
            lk_req_ready = ~cam_busy & ~wr_req_valid & ~RST;
            if (wr_acc)
               state_nxt = WR_ISSUE;
            else if (lk_acc)
               state_nxt = LK_WAIT;
         end
         WR_ISSUE: begin
            cam_we      = 1'b1;
            cam_addr_wr = wr_addr_q;
            cam_din     = wr_data_q;
            state_nxt   = WR_WAIT;
         end
         WR_WAIT: begin
            // First WR_WAIT cycle ignores cam_busy: the CAM may not have raised it yet.
            if (!settle && !cam_busy)
               state_nxt = IDLE;
         end
         LK_WAIT: begin
            cam_cmp_din = key_q;
            if (lat_cnt == 3'd0)
               state_nxt = LK_RESP;
         end
         LK_RESP: begin
            lk_rsp_valid = 1'b1;
            if (lk_rsp_ready)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state     <= IDLE;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         key_q     <= '0;
         lat_cnt   <= 3'd0;
         settle    <= 1'b0;
      end else begin
         state <= state_nxt;
         if (wr_acc) begin
            wr_addr_q <= wr_req_addr;
            wr_data_q <= wr_req_data;
         end
         if (state == WR_ISSUE)
            settle <= 1'b1;
         else if (state == WR_WAIT)
            settle <= 1'b0;
         if (lk_acc) begin
            key_q   <= lk_req_key;
            lat_cnt <= LAT;
         end else if (state == LK_WAIT && lat_cnt != 3'd0) begin
            lat_cnt <= lat_cnt - 3'd1;
         end
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         lk_rsp_hit   <= 1'b0;
         lk_rsp_addr  <= '0;
         stat_lookups <= '0;
         stat_hits    <= '0;
      end else begin
         if (sample) begin
            lk_rsp_hit  <= cam_match;
            lk_rsp_addr <= cam_match ? cam_match_addr : '0;
         end
         if (lk_acc && stat_lookups != 32'hFFFF_FFFF)
            stat_lookups <= stat_lookups + 32'd1;
         if (sample && cam_match && stat_hits != 32'hFFFF_FFFF)
            stat_hits <= stat_hits + 32'd1;
      end
   end

endmodule

// File: tb/tb_cam_lookup_ctrl.sv
// tb/tb_cam_lookup_ctrl.sv - scoreboard bench for cam_lookup_ctrl with a behavioral CAM.
module tb_cam_lookup_ctrl;
   localparam int AW = 5;
   localparam int DW = 16;
   localparam int LAT = 2;
   localparam int TOUT = 200;

   logic CLK = 1'b0;
   logic RST = 1'b1;
   logic wr_req_valid, wr_req_ready, lk_req_valid, lk_req_ready;
   logic lk_rsp_valid, lk_rsp_ready, lk_rsp_hit, cam_we, cam_busy, cam_match;
   logic [AW-1:0] wr_req_addr, lk_rsp_addr, cam_addr_wr, cam_match_addr;
   logic [DW-1:0] wr_req_data, lk_req_key, cam_din, cam_cmp_din;
   logic [31:0] stat_lookups, stat_hits;

   always #5 CLK = ~CLK;

   cam_lookup_ctrl #(
      .C_TCAM_ADDR_WIDTH(AW), .C_TCAM_DATA_WIDTH(DW), .C_LOOKUP_LATENCY(LAT)
   ) dut (
      .CLK(CLK), .RST(RST),
      .wr_req_valid(wr_req_valid), .wr_req_ready(wr_req_ready),
      .wr_req_addr(wr_req_addr), .wr_req_data(wr_req_data),
      .lk_req_valid(lk_req_valid), .lk_req_ready(lk_req_ready), .lk_req_key(lk_req_key),
      .lk_rsp_valid(lk_rsp_valid), .lk_rsp_ready(lk_rsp_ready),
      .lk_rsp_hit(lk_rsp_hit), .lk_rsp_addr(lk_rsp_addr),
      .cam_we(cam_we), .cam_addr_wr(cam_addr_wr), .cam_din(cam_din), .cam_busy(cam_busy),
      .cam_cmp_din(cam_cmp_din), .cam_match(cam_match), .cam_match_addr(cam_match_addr),
      .stat_lookups(stat_lookups), .stat_hits(stat_hits)
   );

   // Behavioral CAM: 3-cycle busy after a write, match valid LAT cycles after the key.
   logic [DW-1:0] cmem [32];
   logic [31:0]   cval;
   logic [DW-1:0] dly [LAT];
   int            busy_cnt;
   logic          busy_ext;

   always @(posedge CLK or posedge RST) begin
      if (RST) begin
         cval <= '0;
         busy_cnt <= 0;
         for (int i = 0; i < LAT; i++) dly[i] <= '0;
      end else begin
         if (cam_we) begin
            cmem[cam_addr_wr] <= cam_din;
            cval[cam_addr_wr] <= 1'b1;
            busy_cnt <= 3;
         end else if (busy_cnt > 0) begin
            busy_cnt <= busy_cnt - 1;
         end
         dly[0] <= cam_cmp_din;
         for (int i = 1; i < LAT; i++) dly[i] <= dly[i-1];
      end
   end

   assign cam_busy = (busy_cnt != 0) | busy_ext;

   always_comb begin
      cam_match = 1'b0;
      cam_match_addr = 5'h15;
      for (int i = 31; i >= 0; i--) begin
         if (cval[i] && cmem[i] == dly[LAT-1]) begin
            cam_match = 1'b1;
            cam_match_addr = AW'(i);
         end
      end
   end

   typedef struct packed {logic hit; logic [AW-1:0] addr;} rsp_t;
   rsp_t          exp_q[$];
   rsp_t          exp_r;
   logic [DW-1:0] ref_mem [32];
   logic [31:0]   ref_val;
   logic [DW-1:0] keys [4];
   int            nkeys;
   int            n_checks = 0;
   int            n_errors = 0;
   int            cyc = 0;
   int            we_cyc, cmp_cyc, wr_acc_cyc;
   int            acc_cyc[$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   function automatic rsp_t ref_lookup(input logic [DW-1:0] key);
      rsp_t r = '0;
      for (int i = 31; i >= 0; i--) begin
         if (ref_val[i] && ref_mem[i] == key) begin
            r.hit = 1'b1;
            r.addr = AW'(i);
         end
      end
      return r;
   endfunction

   always @(negedge CLK) begin
      cyc = cyc + 1;
      if (!RST) begin
         if (cam_we) we_cyc = cyc;
         if (cam_cmp_din != '0 && cmp_cyc < 0) cmp_cyc = cyc;
         if (wr_req_valid && wr_req_ready) wr_acc_cyc = cyc;
         if (lk_req_valid && lk_req_ready) acc_cyc.push_back(cyc);
         if (lk_rsp_valid && lk_rsp_ready) begin
            if (exp_q.size() == 0) begin
               chk("rsp_unexpected", {31'b0, lk_rsp_valid}, 32'd0);
            end else begin
               exp_r = exp_q.pop_front();
               chk("rsp_hit", {31'b0, lk_rsp_hit}, {31'b0, exp_r.hit});
               chk("rsp_addr", {27'b0, lk_rsp_addr}, {27'b0, exp_r.addr});
            end
         end
      end
   end

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic wait_lk_accept(output bit ok);
      int n = 0;
      @(negedge CLK);
      while (!lk_req_ready && n < TOUT) begin
         @(negedge CLK);
         n++;
      end
      ok = lk_req_ready;
      if (!ok) chk("lk_accept", {31'b0, lk_req_ready}, 32'd1);
   endtask

   task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] data);
      int n = 0;
      wr_req_valid = 1'b1;
      wr_req_addr = addr;
      wr_req_data = data;
      @(negedge CLK);
      while (!wr_req_ready && n < TOUT) begin
         @(negedge CLK);
         n++;
      end
      if (!wr_req_ready) chk("wr_accept", {31'b0, wr_req_ready}, 32'd1);
      else begin
         ref_mem[addr] = data;
         ref_val[addr] = 1'b1;
      end
      step();
      wr_req_valid = 1'b0;
   endtask

   task automatic lookup_keys();
      bit ok;
      lk_req_valid = 1'b1;
      for (int k = 0; k < nkeys; k++) begin
         lk_req_key = keys[k];
         wait_lk_accept(ok);
         if (!ok) break;
         exp_q.push_back(ref_lookup(keys[k]));
         step();
      end
      lk_req_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < TOUT) begin
         step();
         n++;
      end
      chk("drain", exp_q.size(), 32'd0);
   endtask

   initial begin
      bit ok;
      bit stable;
      logic h;
      logic [AW-1:0] a;
      int n;
      wr_req_valid = 0; wr_req_addr = '0; wr_req_data = '0;
      lk_req_valid = 1; lk_req_key = '0; lk_rsp_ready = 1;
      busy_ext = 0; ref_val = '0; nkeys = 0;
      we_cyc = -1; cmp_cyc = -1; wr_acc_cyc = -1;

      // Reset state
      repeat (3) @(negedge CLK);
      chk("rst_wr_ready", {31'b0, wr_req_ready}, 32'd0);
      chk("rst_lk_ready", {31'b0, lk_req_ready}, 32'd0);
      chk("rst_cam_we", {31'b0, cam_we}, 32'd0);
      chk("rst_cam_addr_wr", {27'b0, cam_addr_wr}, 32'd0);
      chk("rst_cam_din", {16'b0, cam_din}, 32'd0);
      chk("rst_cam_cmp_din", {16'b0, cam_cmp_din}, 32'd0);
      chk("rst_rsp_valid", {31'b0, lk_rsp_valid}, 32'd0);
      chk("rst_rsp_hit", {31'b0, lk_rsp_hit}, 32'd0);
      chk("rst_rsp_addr", {27'b0, lk_rsp_addr}, 32'd0);
      chk("rst_stat_lookups", stat_lookups, 32'd0);
      chk("rst_stat_hits", stat_hits, 32'd0);
      lk_req_valid = 0;
      step();
      RST = 0;
      step();

      // Three writes, three back-to-back lookups
      do_write(5'h00, 16'h1234);
      do_write(5'h0f, 16'habcd);
      do_write(5'h1e, 16'h5678);
      acc_cyc.delete();
      keys[0] = 16'h1234; keys[1] = 16'habcd; keys[2] = 16'h5678; nkeys = 3;
      lookup_keys();
      drain();
      chk("throughput_0", acc_cyc[1] - acc_cyc[0], LAT + 3);
      chk("throughput_1", acc_cyc[2] - acc_cyc[1], LAT + 3);
      chk("stat_lookups_3", stat_lookups, 32'd3);
      chk("stat_hits_3", stat_hits, 32'd3);

      // Miss
      keys[0] = 16'hdead; nkeys = 1;
      lookup_keys();
      drain();
      chk("miss_stat_hits", stat_hits, 32'd3);
      chk("miss_stat_lookups", stat_lookups, 32'd4);

      // Write and lookup offered in the same cycle
      we_cyc = -1; cmp_cyc = -1; acc_cyc.delete();
      wr_req_valid = 1; wr_req_addr = 5'h03; wr_req_data = 16'h0f0f;
      lk_req_valid = 1; lk_req_key = 16'h0f0f;
      @(negedge CLK);
      chk("both_wr_ready", {31'b0, wr_req_ready}, 32'd1);
      chk("both_lk_ready", {31'b0, lk_req_ready}, 32'd0);
      ref_mem[3] = 16'h0f0f;
      ref_val[3] = 1'b1;
      step();
      wr_req_valid = 0;
      wait_lk_accept(ok);
      if (ok) begin
         chk("lk_acc_busy", {31'b0, cam_busy}, 32'd0);
         exp_q.push_back(ref_lookup(16'h0f0f));
      end
      step();
      lk_req_valid = 0;
      drain();
      chk("we_before_cmp", {31'b0, (we_cyc >= 0 && cmp_cyc > we_cyc)}, 32'd1);
      chk("lk_after_wr_delay", acc_cyc[0] - wr_acc_cyc, 32'd6);

      // cam_busy blocks in IDLE, is ignored while a lookup is in flight
      busy_ext = 1;
      lk_req_valid = 1; lk_req_key = 16'h1234;
      stable = 1;
      repeat (4) begin
         @(negedge CLK);
         stable &= !lk_req_ready && !wr_req_ready;
      end
      chk("busy_blocks", {31'b0, stable}, 32'd1);
      step();
      busy_ext = 0;
      @(negedge CLK);
      chk("busy_release_ready", {31'b0, lk_req_ready}, 32'd1);
      exp_q.push_back(ref_lookup(16'h1234));
      step();
      lk_req_valid = 0;
      busy_ext = 1;
      drain();
      busy_ext = 0;
      step();

      // Response backpressure
      lk_rsp_ready = 0;
      lk_req_valid = 1; lk_req_key = 16'h5678;
      wait_lk_accept(ok);
      if (ok) exp_q.push_back(ref_lookup(16'h5678));
      step();
      lk_req_key = 16'habcd;
      n = 0;
      @(negedge CLK);
      while (!lk_rsp_valid && n < TOUT) begin
         @(negedge CLK);
         n++;
      end
      chk("bp_rsp_valid", {31'b0, lk_rsp_valid}, 32'd1);
      h = lk_rsp_hit;
      a = lk_rsp_addr;
      stable = 1;
      repeat (10) begin
         @(negedge CLK);
         stable &= lk_rsp_valid && lk_rsp_hit == h && lk_rsp_addr == a && !lk_req_ready;
      end
      chk("bp_hold_stable", {31'b0, stable}, 32'd1);
      step();
      lk_rsp_ready = 1;
      @(negedge CLK);
      @(negedge CLK);
      chk("bp_idle_rsp_valid", {31'b0, lk_rsp_valid}, 32'd0);
      chk("bp_idle_lk_ready", {31'b0, lk_req_ready}, 32'd1);
      exp_q.push_back(ref_lookup(16'habcd));
      step();
      lk_req_valid = 0;
      drain();

      // Reset during LK_WAIT
      lk_req_valid = 1; lk_req_key = 16'h1234;
      wait_lk_accept(ok);
      step();
      RST = 1;
      #1;
      chk("mid_rst_cmp_din", {16'b0, cam_cmp_din}, 32'd0);
      chk("mid_rst_rsp_valid", {31'b0, lk_rsp_valid}, 32'd0);
      chk("mid_rst_lk_ready", {31'b0, lk_req_ready}, 32'd0);
      chk("mid_rst_stat_lookups", stat_lookups, 32'd0);
      chk("mid_rst_stat_hits", stat_hits, 32'd0);
      chk("mid_rst_rsp_hit", {31'b0, lk_rsp_hit}, 32'd0);
      ref_val = '0;
      repeat (3) @(negedge CLK);
      step();
      RST = 0;
      @(negedge CLK);
      chk("post_rst_first_accept", {31'b0, lk_req_ready}, 32'd1);
      exp_q.push_back(ref_lookup(16'h1234));
      step();
      lk_req_valid = 0;
      drain();
      chk("post_rst_stat_lookups", stat_lookups, 32'd1);
      do_write(5'h07, 16'h1234);
      keys[0] = 16'h1234; nkeys = 1;
      lookup_keys();
      drain();

      // stat_hits saturation
      step();
      force dut.stat_hits = 32'hFFFF_FFFE;
      @(negedge CLK);
      step();
      release dut.stat_hits;
      keys[0] = 16'h1234; keys[1] = 16'h1234; keys[2] = 16'h1234; nkeys = 3;
      lookup_keys();
      drain();
      chk("stat_hits_sat", stat_hits, 32'hFFFF_FFFF);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1);
   end

endmodule

// File: doc/cam_lookup_ctrl.md
CAM_LOOKUP_CTRL -- requirements
Module: cam_lookup_ctrl

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- C_TCAM_ADDR_WIDTH, 5, CAM entry address width.
- C_TCAM_DATA_WIDTH, 16, CAM key width.
- C_LOOKUP_LATENCY, 1, cycles from cam_cmp_din applied to cam_match/cam_match_addr valid (1..7).

REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- CLK  in  1  single clock; all logic on rising edge.
- RST  in  1  reset, asynchronous, active-high.
- wr_req_valid  in  1  write request present.
- wr_req_ready  out  1  write request accepted this cycle when both high.
- wr_req_addr  in  C_TCAM_ADDR_WIDTH  entry to write.
- wr_req_data  in  C_TCAM_DATA_WIDTH  key to store.
- lk_req_valid  in  1  lookup request present.
- lk_req_ready  out  1  lookup accepted when both high.
- lk_req_key  in  C_TCAM_DATA_WIDTH  key to search.
- lk_rsp_valid  out  1  lookup result present.
- lk_rsp_ready  in  1  result consumed when both high.
- lk_rsp_hit  out  1  match found.
- lk_rsp_addr  out  C_TCAM_ADDR_WIDTH  matching entry; 0 on miss.
- cam_we  out  1  CAM write enable.
- cam_addr_wr  out  C_TCAM_ADDR_WIDTH  CAM write address.
- cam_din  out  C_TCAM_DATA_WIDTH  CAM write data.
- cam_busy  in  1  CAM write in progress.
- cam_cmp_din  out  C_TCAM_DATA_WIDTH  CAM compare key.
- cam_match  in  1  CAM hit.
- cam_match_addr  in  C_TCAM_ADDR_WIDTH  CAM hit address.
- stat_lookups  out  32  accepted lookups, saturating.
- stat_hits  out  32  hit responses, saturating.

Function
REQ-003 The block SHALL implement the FSM states IDLE, WR_ISSUE, WR_WAIT, LK_WAIT and LK_RESP, with at most one operation outstanding.
REQ-004 In IDLE, wr_req_ready SHALL equal ~cam_busy and lk_req_ready SHALL equal ~cam_busy & ~wr_req_valid; both SHALL be 0 in every other state.
REQ-005 A write SHALL take priority when both requests are valid in the same IDLE cycle; the lookup waits.
REQ-006 On write acceptance the block SHALL register addr/data and enter WR_ISSUE.
REQ-007 In WR_ISSUE, cam_we SHALL be 1 for exactly one cycle with the registered cam_addr_wr/cam_din, then the FSM SHALL enter WR_WAIT.
REQ-008 The FSM SHALL leave WR_WAIT for IDLE on the first cycle at least 2 cycles after WR_ISSUE in which cam_busy=0.
REQ-009 cam_we, cam_addr_wr and cam_din SHALL be 0 outside WR_ISSUE.
REQ-010 On lookup acceptance the key SHALL be registered and driven on cam_cmp_din from the next cycle through the sampling cycle; the FSM SHALL enter LK_WAIT and load a latency counter with C_LOOKUP_LATENCY.
REQ-011 cam_cmp_din SHALL be 0 whenever not in LK_WAIT.
REQ-012 In LK_WAIT the counter SHALL decrement each cycle; cam_match/cam_match_addr SHALL be sampled exactly C_LOOKUP_LATENCY cycles after cam_cmp_din first carries the key, then the FSM SHALL enter LK_RESP.
REQ-013 In LK_RESP, lk_rsp_valid SHALL be 1 and lk_rsp_hit/lk_rsp_addr SHALL stay stable until lk_rsp_ready=1, then the FSM SHALL return to IDLE the following cycle.
REQ-014 Back-to-back lookup throughput SHALL be one per C_LOOKUP_LATENCY+3 cycles when lk_rsp_ready is held at 1.
REQ-015 On a miss, lk_rsp_addr SHALL be 0 regardless of cam_match_addr.
REQ-016 stat_lookups SHALL increment on each lookup acceptance and stat_hits on each LK_RESP entry with a hit; both SHALL hold at 32'hFFFFFFFF once reached.
REQ-017 cam_busy asserted in IDLE SHALL block both requests; it SHALL be ignored in the lookup states.

Reset
REQ-018 While RST=1, asynchronously: FSM=IDLE; cam_we=0, cam_addr_wr=0, cam_din=0, cam_cmp_din=0; lk_rsp_valid=0, lk_rsp_hit=0, lk_rsp_addr=0; stat counters=0; ready outputs=0.
REQ-019 A reset asserted mid-write or mid-lookup SHALL drop the operation without a response; the first request SHALL be accepted in the first IDLE cycle after RST deasserts.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Writes 16'h1234@0, 16'habcd@0xf, 16'h5678@0x1e, then lookups of each key -> three responses, hit=1, addr 0/0xf/0x1e; stat_lookups=3, stat_hits=3.
- Lookup 16'hdead -> hit=0, addr=0, stat_hits unchanged.
- Write and lookup valid in the same cycle -> cam_we pulse precedes any nonzero cam_cmp_din; the lookup is accepted only after cam_busy falls.
- lk_rsp_ready held 0 for 10 cycles -> response held stable; no new lookup accepted; release -> IDLE next cycle.
- RST pulsed during LK_WAIT -> no lk_rsp_valid; all outputs 0; the next lookup completes normally.
- stat_hits preloaded near saturation via forced sequence -> holds at 32'hFFFFFFFF.
